// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive controllers.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  localparam logic        LINE_IDLE            = 1'b1;
  localparam int unsigned DEFAULT_OVERSAMPLING = 16;
  localparam int unsigned MAX_DATA_BITS        = 9;
  localparam int unsigned BIT_CNT_W            = $clog2(MAX_DATA_BITS + 1);

  // Zero padding of narrower words leaves the reduction unchanged.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic                     odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts oversampled baud ticks and flags the tick that closes a bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLING = DEFAULT_OVERSAMPLING
) (
  input  logic i_clk,
  input  logic i_aresetn,
  input  logic i_clear,
  input  logic i_baud_tick,
  output logic o_bit_done
);

  localparam int unsigned CNT_W = (OVERSAMPLING > 2) ? $clog2(OVERSAMPLING) : 1;

  logic [CNT_W-1:0] tick_cnt;
  logic             at_last;

  assign at_last    = (tick_cnt == CNT_W'(OVERSAMPLING - 1));
  // Combinational so the owning FSM can advance on the very tick that ends the bit.
  assign o_bit_done = i_baud_tick && at_last && !i_clear;

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      tick_cnt <= '0;
    end else if (i_clear) begin
      tick_cnt <= '0;
    end else if (i_baud_tick) begin
      tick_cnt <= at_last ? '0 : tick_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: valid/ready word in, framed serial stream out,
// each bit held for OVERSAMPLING baud ticks.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned OVERSAMPLING = DEFAULT_OVERSAMPLING,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_aresetn,
  input  logic                 i_baud_tick,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy
);

  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS || OVERSAMPLING < 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
    $fatal(1, "uart_tx_ctrl: illegal DATA_BITS/OVERSAMPLING/STOP_BITS");
  end

  tx_state_t              state;
  tx_state_t              state_next;
  logic [DATA_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]   shreg_next;
  logic                   parity_bit;
  logic                   parity_next;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [BIT_CNT_W-1:0]   bit_cnt_next;
  logic                   bit_done;
  logic                   tx_next;
  logic                   ready_next;
  logic                   busy_next;

  // Holding the timer clear in IDLE discards idle ticks and the acceptance tick.
  uart_bit_timer #(
    .OVERSAMPLING (OVERSAMPLING)
  ) u_bit_timer (
    .i_clk       (i_clk),
    .i_aresetn   (i_aresetn),
    .i_clear     (state == TX_IDLE),
    .i_baud_tick (i_baud_tick),
    .o_bit_done  (bit_done)
  );

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state <= TX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      shreg      <= '0;
      parity_bit <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      shreg      <= shreg_next;
      parity_bit <= parity_next;
      bit_cnt    <= bit_cnt_next;
    end
  end

  // Next state and datapath; bit_cnt counts data bits in DATA and stop bits in STOP.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    parity_next  = parity_bit;
    bit_cnt_next = bit_cnt;
    case (state)
      TX_IDLE: begin
        if (i_valid) begin
          state_next   = TX_START;
          shreg_next   = i_data;
          parity_next  = parity_calc(MAX_DATA_BITS'(i_data), PARITY_ODD);
          bit_cnt_next = '0;
        end
      end
      TX_START: begin
        if (bit_done) begin
          state_next   = TX_DATA;
          bit_cnt_next = '0;
        end
      end
      TX_DATA: begin
        if (bit_done) begin
          shreg_next = shreg >> 1;
          if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
            state_next   = PARITY_EN ? TX_PARITY : TX_STOP;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
          end
        end
      end
      TX_PARITY: begin
        if (bit_done) begin
          state_next   = TX_STOP;
          bit_cnt_next = '0;
        end
      end
      TX_STOP: begin
        if (bit_done) begin
          if (bit_cnt == BIT_CNT_W'(STOP_BITS - 1)) begin
            state_next = TX_IDLE;
          end else begin
            bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = TX_IDLE;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so the registered pins track it exactly.
  always_comb begin
    tx_next    = LINE_IDLE;
    ready_next = 1'b0;
    busy_next  = 1'b1;
    case (state_next)
      TX_IDLE: begin
        ready_next = 1'b1;
        busy_next  = 1'b0;
      end
      TX_START:  tx_next = ~LINE_IDLE;
      TX_DATA:   tx_next = shreg_next[0];
      TX_PARITY: tx_next = parity_next;
      TX_STOP:   tx_next = LINE_IDLE;
      default:   tx_next = LINE_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_tx    <= LINE_IDLE;
      o_ready <= 1'b1;
      o_busy  <= 1'b0;
    end else begin
      o_tx    <= tx_next;
      o_ready <= ready_next;
      o_busy  <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: three configurations share clock, reset,
// tick and the word source; each accepted word is checked tick by tick on the line.
module tb_uart_tx_ctrl;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx    [NDUT];
  logic       ready [NDUT];
  logic       busy  [NDUT];

  int checks = 0;
  int errors = 0;
  int tick_mode = 1;
  int acc = 0;
  logic prev_tick = 1'b0;

  logic        in_frame  [NDUT];
  int          n_tick    [NDUT];
  logic [15:0] cur_frame [NDUT];
  int          pushed    [NDUT];
  logic [15:0] exp_q     [NDUT][$];

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_BITS(8), .OVERSAMPLING(16), .PARITY_EN(1'b0),
                 .PARITY_ODD(1'b0), .STOP_BITS(1)) dut_a (
    .i_clk(clk), .i_aresetn(rst_n), .i_baud_tick(tick), .i_data(data),
    .i_valid(valid), .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0]));

  uart_tx_ctrl #(.DATA_BITS(8), .OVERSAMPLING(16), .PARITY_EN(1'b1),
                 .PARITY_ODD(1'b0), .STOP_BITS(2)) dut_b (
    .i_clk(clk), .i_aresetn(rst_n), .i_baud_tick(tick), .i_data(data),
    .i_valid(valid), .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1]));

  uart_tx_ctrl #(.DATA_BITS(8), .OVERSAMPLING(4), .PARITY_EN(1'b1),
                 .PARITY_ODD(1'b1), .STOP_BITS(1)) dut_c (
    .i_clk(clk), .i_aresetn(rst_n), .i_baud_tick(tick), .i_data(data),
    .i_valid(valid), .o_ready(ready[2]), .o_tx(tx[2]), .o_busy(busy[2]));

  function automatic int os_of(input int d);
    return (d == 2) ? 4 : 16;
  endfunction
  function automatic logic pe_of(input int d);
    return (d != 0);
  endfunction
  function automatic logic po_of(input int d);
    return (d == 2);
  endfunction
  function automatic int st_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction
  function automatic int flen(input int d);
    return 1 + 8 + int'(pe_of(d)) + st_of(d);
  endfunction

  // Expected line bits, index 0 first on the wire; positions past the payload are stop (1).
  function automatic logic [15:0] make_frame(input logic [7:0] w, input int d);
    logic [15:0] f;
    f    = 16'hFFFF;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = w[i];
    if (pe_of(d)) f[9] = logic'($countones(w) % 2) ^ po_of(d);
    return f;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut=%0d t=%0t actual=%0h expected=%0h", name, d, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Baud tick source, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (tick_mode)
        0: tick = 1'b0;
        1: tick = 1'b1;
        2: begin
          acc = acc + 1843200;
          if (acc >= 100000000) begin
            acc  = acc - 100000000;
            tick = 1'b1;
          end else begin
            tick = 1'b0;
          end
        end
        default: tick = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  task automatic mon_step(input int d);
    int bitn;
    if (!rst_n) begin
      in_frame[d] = 1'b0;
      chk("rst_tx", d, 32'(tx[d]), 32'd1);
      chk("rst_ready", d, 32'(ready[d]), 32'd1);
      chk("rst_busy", d, 32'(busy[d]), 32'd0);
      return;
    end
    if (valid && ready[d]) begin
      exp_q[d].push_back(make_frame(data, d));
      pushed[d]++;
    end
    if (in_frame[d]) begin
      if (prev_tick) n_tick[d]++;
      if (n_tick[d] < flen(d) * os_of(d)) begin
        bitn = n_tick[d] / os_of(d);
        chk("frame_tx", d, 32'(tx[d]), 32'(cur_frame[d][bitn]));
        chk("frame_busy", d, 32'(busy[d]), 32'd1);
        chk("frame_ready", d, 32'(ready[d]), 32'd0);
      end else begin
        chk("end_tx", d, 32'(tx[d]), 32'd1);
        chk("end_busy", d, 32'(busy[d]), 32'd0);
        chk("end_ready", d, 32'(ready[d]), 32'd1);
        in_frame[d] = 1'b0;
      end
    end else if (busy[d]) begin
      checks++;
      if (exp_q[d].size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame dut=%0d t=%0t actual=busy expected=idle", d, $time);
      end else begin
        cur_frame[d] = exp_q[d].pop_front();
        in_frame[d]  = 1'b1;
        n_tick[d]    = 0;
        chk("start_tx", d, 32'(tx[d]), 32'd0);
        chk("start_ready", d, 32'(ready[d]), 32'd0);
      end
    end else begin
      chk("idle_tx", d, 32'(tx[d]), 32'd1);
      chk("idle_ready", d, 32'(ready[d]), 32'd1);
    end
  endtask

  // Monitor: samples on the falling edge, pops an expected frame when a DUT goes busy.
  initial begin
    for (int d = 0; d < NDUT; d++) begin
      in_frame[d] = 1'b0;
      n_tick[d]   = 0;
      pushed[d]   = 0;
      cur_frame[d] = 16'hFFFF;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) mon_step(d);
      prev_tick = tick;
    end
  end

  function automatic bit all_idle();
    bit r;
    r = 1'b1;
    for (int d = 0; d < NDUT; d++)
      if (in_frame[d] || busy[d] || exp_q[d].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_idle(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      cyc();
      if (all_idle()) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL idle_timeout t=%0t actual=busy expected=idle within %0d cycles", $time, max_cyc);
    end
  endtask

  task automatic send(input logic [7:0] w);
    data  = w;
    valid = 1'b1;
    cyc();
    valid = 1'b0;
    data  = 8'($urandom);
  endtask

  initial begin
    int p [NDUT];
    bit got;
    tick_mode = 1;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    send(8'h55);
    wait_idle(400);
    send(8'hA7);
    wait_idle(400);

    // Fractional tick generator approximating 100 MHz / (115200 * 16).
    tick_mode = 2;
    send(8'h00);
    wait_idle(20000);

    // Back-to-back with valid held; data changes while the first frame is in flight.
    tick_mode = 1;
    for (int d = 0; d < NDUT; d++) p[d] = pushed[d];
    data  = 8'h12;
    valid = 1'b1;
    cyc();
    data = 8'h34;
    got  = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      cyc();
      if (pushed[0] >= p[0] + 2 && pushed[1] >= p[1] + 2 && pushed[2] >= p[2] + 2) begin
        got = 1'b1;
        break;
      end
    end
    valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL b2b_second_accept t=%0t actual=missing expected=accepted", $time);
    end
    wait_idle(600);

    // Reset during data bit 3 of the 16x configurations.
    send(8'h3C);
    repeat (16 + 16 * 3 + 5) cyc();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("async_rst_tx", d, 32'(tx[d]), 32'd1);
      chk("async_rst_ready", d, 32'(ready[d]), 32'd1);
      chk("async_rst_busy", d, 32'(busy[d]), 32'd0);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    send(8'hF0);
    wait_idle(400);

    // Ticks stopped from acceptance: line must hold the start bit until they resume.
    tick_mode = 0;
    send(8'h96);
    repeat (300) cyc();
    tick_mode = 1;
    wait_idle(400);

    // Random words, valid and tick phase.
    tick_mode = 3;
    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(0, 2) == 0);
      data  = 8'($urandom);
      cyc();
    end
    valid = 1'b0;
    wait_idle(3000);

    for (int d = 0; d < NDUT; d++) chk("queue_empty", d, 32'(exp_q[d].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
